// File: rtl/instr_loader_pkg.sv
// Shared core definitions: decodable opcodes and loader FSM states.
package instr_loader_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} loader_state_t;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_ALUI, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input, imem write port and boot status of the program loader.
interface instr_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [15:0]       bad_op_cnt;

  // master: byte source / observer; slave: the loader itself
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err, bad_op_cnt
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_hold, done, err, bad_op_cnt
  );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_vld_o fires combinationally
// on the 4th byte's transfer, with word_dat_o holding the completed word.
module instr_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic [1:0]  byte_idx_o,
  output logic        word_vld_o,
  output logic [31:0] word_dat_o
);

  // Only the three earlier bytes need storage; the 4th arrives on the input.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (byte_vld_i) begin
      shift_d = {byte_dat_i, shift_q[23:8]};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_idx_o = idx_q;
  assign word_vld_o = byte_vld_i && (idx_q == 2'd3);
  assign word_dat_o = {byte_dat_i, shift_q};

endmodule

// File: rtl/instr_loader.sv
// Boot loader: length-prefixed LE byte stream -> imem words, then releases the core.
// The write strobe and S_DONE land on the same edge, so done rises with the last imem_we.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  instr_loader_if.slave bus
);

  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [32:0]       CAP      = 33'(1) << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       bad_q, bad_d;

  logic        xfer;
  logic        word_vld;
  logic [1:0]  byte_idx;
  logic [31:0] word;

  assign bus.rx_ready = (state_q == S_LEN) || (state_q == S_DATA);
  assign xfer         = bus.rx_valid && bus.rx_ready;

  instr_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_vld_i (xfer),
    .byte_dat_i (bus.rx_data),
    .byte_idx_o (byte_idx),
    .word_vld_o (word_vld),
    .word_dat_o (word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    idle_d  = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;

    unique case (state_q)
      S_LEN: begin
        if (word_vld) begin
          if (word == 32'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, word} > CAP) begin
            state_d = S_ERR;
          end else begin
            n_d     = word[ADDR_W:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_vld) begin
          we_d    = 1'b1;
          addr_d  = BASE_A + widx_q[ADDR_W-1:0];
          wdata_d = word;
          widx_d  = widx_q + CNT_ONE;
          if (!op_supported(word[6:0]) && (bad_q != 16'hFFFF)) begin
            bad_d = bad_q + 16'd1;
          end
          if (widx_q == n_q - CNT_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      default: ;
    endcase

    // Only a stalled partial word or length is timed; idle between words is fine.
    if ((TIMEOUT_CYC > 0) && bus.rx_ready && (byte_idx != 2'd0) && !xfer) begin
      idle_d = idle_q + IDLE_ONE;
      if (idle_d == IDLE_LIM) begin
        state_d = S_ERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN;
      n_q     <= '0;
      widx_q  <= '0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);
  assign bus.core_hold  = (state_q != S_DONE);
  assign bus.bad_op_cnt = bad_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a small loader (ADDR_W=4, BASE 0, no timeout) and a
// large one (ADDR_W=10, BASE 5, TIMEOUT 8) share the stimulus driver via sel.
`timescale 1ns/1ps
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(4))  bus0 ();
  instr_loader_if #(.ADDR_W(10)) bus1 ();

  assign bus0.rx_valid = rx_valid && !sel;
  assign bus0.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid && sel;
  assign bus1.rx_data  = rx_data;

  instr_loader #(.ADDR_W(4), .BASE_ADDR(0), .TIMEOUT_CYC(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  instr_loader #(.ADDR_W(10), .BASE_ADDR(5), .TIMEOUT_CYC(8)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  logic        o_ready, o_we, o_hold, o_done, o_err;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata;
  logic [15:0] o_bad;

  always_comb begin
    if (sel) begin
      o_ready = bus1.rx_ready; o_we = bus1.imem_we; o_hold = bus1.core_hold;
      o_done = bus1.done; o_err = bus1.err; o_addr = bus1.imem_addr;
      o_wdata = bus1.imem_wdata; o_bad = bus1.bad_op_cnt;
    end else begin
      o_ready = bus0.rx_ready; o_we = bus0.imem_we; o_hold = bus0.core_hold;
      o_done = bus0.done; o_err = bus0.err; o_addr = {6'd0, bus0.imem_addr};
      o_wdata = bus0.imem_wdata; o_bad = bus0.bad_op_cnt;
    end
  end

  // Every cycle with imem_we high is one recorded write; a stretched strobe shows up as extras.
  int          got_a[$];
  logic [31:0] got_d[$];
  logic        got_fin[$];

  always @(negedge clk) begin
    if (o_we) begin
      got_a.push_back(int'(o_addr));
      got_d.push_back(o_wdata);
      got_fin.push_back(o_done && !o_hold);
    end
  end

  int total = 0;
  int nbad  = 0;

  int          hdr_n;
  logic [31:0] words[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_done, exp_err;
  int          exp_bad;
  logic [6:0]  legal_ops [7] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F};

  function automatic bit legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F};
  endfunction

  // Reference: what a loader of this capacity/base must end up doing with the stream.
  task automatic model(input int cap, input int base);
    exp_a.delete(); exp_d.delete();
    exp_bad = 0; exp_done = 1'b0; exp_err = 1'b0;
    if (hdr_n == 0) begin
      exp_done = 1'b1;
    end else if (hdr_n > cap) begin
      exp_err = 1'b1;
    end else begin
      exp_done = (words.size() >= hdr_n);
      for (int i = 0; i < hdr_n && i < words.size(); i++) begin
        exp_a.push_back((base + i) % cap);
        exp_d.push_back(words[i]);
        if (!legal(words[i][6:0])) exp_bad++;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, output logic acc);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    acc      = v && o_ready;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cyc(1'b0, 8'h00, acc);
  endtask

  task automatic gap(input int mx);
    if (mx > 0) idle($urandom_range(mx, 0));
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; sel = s;
    @(negedge clk);
    got_a.delete(); got_d.delete(); got_fin.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic play(input int max_gap);
    logic acc;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      gap(max_gap);
      cyc(1'b1, 8'(hdr_n >> (8 * k)), acc);
    end
    foreach (words[i]) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        gap(max_gap);
        cyc(1'b1, w[8*k +: 8], acc);
      end
    end
    idle(3);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      total++;
      if ({o_ready, o_we, o_hold, o_done, o_err} !== 5'b10100) begin
        nbad++;
        $display("FAIL reset_flags%0d: got rdy/we/hold/done/err=%b want 10100", s,
                 {o_ready, o_we, o_hold, o_done, o_err});
      end
      total++;
      if (o_addr !== 10'd0 || o_wdata !== 32'd0 || o_bad !== 16'd0) begin
        nbad++;
        $display("FAIL reset_regs%0d: got addr=%0d wdata=%h bad=%0d want 0 0 0", s, o_addr, o_wdata, o_bad);
      end
    end
  endtask

  task automatic test_basic();
    do_reset(1'b0);
    hdr_n = 2;
    words = '{32'h00500093, 32'h00108133};
    play(0);
    model(16, 0);
    total++;
    if (got_a.size() !== exp_a.size()) begin
      nbad++; $display("FAIL basic_count: got %0d writes want %0d", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_fin[i] !== (i == exp_a.size() - 1)) begin
        nbad++;
        $display("FAIL basic_wr%0d: got a=%0d d=%h fin=%b want a=%0d d=%h fin=%b", i,
                 got_a[i], got_d[i], got_fin[i], exp_a[i], exp_d[i], i == exp_a.size() - 1);
      end
    end
    total++;
    if ({o_done, o_err, o_hold} !== {exp_done, exp_err, !exp_done} || o_bad !== 16'(exp_bad)) begin
      nbad++;
      $display("FAIL basic_status: got done/err/hold=%b bad=%0d want %b bad=%0d",
               {o_done, o_err, o_hold}, o_bad, {exp_done, exp_err, !exp_done}, exp_bad);
    end
  endtask

  task automatic test_zero_len();
    logic acc;
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'h00, acc);
    total++;
    if (o_done !== 1'b0) begin
      nbad++; $display("FAIL zero_early: got done=%b want 0 before 4th byte", o_done);
    end
    cyc(1'b1, 8'h00, acc);
    cyc(1'b0, 8'h00, acc);
    total++;
    if (o_done !== 1'b1 || o_hold !== 1'b0) begin
      nbad++; $display("FAIL zero_done: got done=%b hold=%b want 1 0", o_done, o_hold);
    end
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'($urandom), acc);
    idle(2);
    total++;
    if (got_a.size() !== 0 || o_ready !== 1'b0 || o_done !== 1'b1) begin
      nbad++;
      $display("FAIL zero_after: got writes=%0d rdy=%b done=%b want 0 0 1", got_a.size(), o_ready, o_done);
    end
  endtask

  task automatic test_capacity();
    do_reset(1'b0);
    hdr_n = 17;
    words.delete();
    repeat (17) words.push_back($urandom);
    play(0);
    total++;
    if ({o_err, o_ready, o_hold, o_done} !== 4'b1010 || got_a.size() !== 0) begin
      nbad++;
      $display("FAIL cap17: got err/rdy/hold/done=%b writes=%0d want 1010 writes=0",
               {o_err, o_ready, o_hold, o_done}, got_a.size());
    end
    do_reset(1'b0);
    hdr_n = 16;
    words.delete();
    repeat (16) words.push_back($urandom);
    play(1);
    model(16, 0);
    total++;
    if (got_a.size() !== exp_a.size()) begin
      nbad++; $display("FAIL cap16_count: got %0d writes want %0d", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_fin[i] !== (i == exp_a.size() - 1)) begin
        nbad++;
        $display("FAIL cap16_wr%0d: got a=%0d d=%h fin=%b want a=%0d d=%h", i,
                 got_a[i], got_d[i], got_fin[i], exp_a[i], exp_d[i]);
      end
    end
    total++;
    if ({o_done, o_err} !== 2'b10 || o_bad !== 16'(exp_bad)) begin
      nbad++;
      $display("FAIL cap16_status: got done/err=%b bad=%0d want 10 bad=%0d", {o_done, o_err}, o_bad, exp_bad);
    end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      do_reset(1'b0);
      hdr_n = 1;
      words = '{32'h0000007F};
      play(6);
      model(16, 0);
      total++;
      if (got_a.size() !== 1 || (got_a.size() == 1 && (got_a[0] !== exp_a[0] || got_d[0] !== exp_d[0]))) begin
        nbad++;
        $display("FAIL gaps_wr%0d: got writes=%0d first d=%h want 1 write d=%h", r, got_a.size(),
                 (got_a.size() > 0) ? got_d[0] : 32'hx, exp_d[0]);
      end
      total++;
      if (o_bad !== 16'(exp_bad) || o_done !== 1'b1) begin
        nbad++; $display("FAIL gaps_bad%0d: got bad=%0d done=%b want %0d 1", r, o_bad, o_done, exp_bad);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b1);
      hdr_n = $urandom_range(8, 1);
      words.delete();
      for (int i = 0; i < hdr_n; i++) begin
        w = $urandom;
        if ($urandom_range(1, 0) == 1) w[6:0] = legal_ops[$urandom_range(6, 0)];
        words.push_back(w);
      end
      play(3);
      model(1024, 5);
      total++;
      if (got_a.size() !== exp_a.size()) begin
        nbad++; $display("FAIL rand%0d_count: got %0d writes want %0d", r, got_a.size(), exp_a.size());
      end
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
        total++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_fin[i] !== (i == exp_a.size() - 1)) begin
          nbad++;
          $display("FAIL rand%0d_wr%0d: got a=%0d d=%h fin=%b want a=%0d d=%h", r, i,
                   got_a[i], got_d[i], got_fin[i], exp_a[i], exp_d[i]);
        end
      end
      total++;
      if ({o_done, o_err, o_hold} !== 3'b100 || o_bad !== 16'(exp_bad)) begin
        nbad++;
        $display("FAIL rand%0d_status: got done/err/hold=%b bad=%0d want 100 bad=%0d", r,
                 {o_done, o_err, o_hold}, o_bad, exp_bad);
      end
    end
  endtask

  task automatic test_timeout();
    logic acc;
    do_reset(1'b1);
    idle(20);
    total++;
    if (o_err !== 1'b0) begin
      nbad++; $display("FAIL to_noload: got err=%b want 0 while idle before first byte", o_err);
    end
    cyc(1'b1, 8'h01, acc);
    idle(8);
    @(negedge clk);
    total++;
    if ({o_err, o_ready, o_hold} !== 3'b101) begin
      nbad++; $display("FAIL to_len: got err/rdy/hold=%b want 101", {o_err, o_ready, o_hold});
    end

    do_reset(1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, (k == 0) ? 8'h01 : 8'h00, acc);
    cyc(1'b1, 8'h13, acc);
    cyc(1'b1, 8'h00, acc);
    idle(8);
    @(negedge clk);
    total++;
    if (o_err !== 1'b1 || got_a.size() !== 0) begin
      nbad++; $display("FAIL to_idle8: got err=%b writes=%0d want 1 0", o_err, got_a.size());
    end

    do_reset(1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, (k == 0) ? 8'h01 : 8'h00, acc);
    cyc(1'b1, 8'h13, acc);
    cyc(1'b1, 8'h00, acc);
    idle(7);
    cyc(1'b1, 8'h00, acc);
    cyc(1'b1, 8'h00, acc);
    idle(2);
    total++;
    if (o_err !== 1'b0 || o_done !== 1'b1 || got_a.size() !== 1 ||
        (got_a.size() == 1 && (got_a[0] !== 5 || got_d[0] !== 32'h00000013))) begin
      nbad++;
      $display("FAIL to_idle7: got err=%b done=%b writes=%0d want 0 1 1 (a=5 d=00000013)",
               o_err, o_done, got_a.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic [31:0] w0;
    w0 = 32'hA5A50033;
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, (k == 0) ? 8'h02 : 8'h00, acc);
    for (int k = 0; k < 4; k++) cyc(1'b1, w0[8*k +: 8], acc);
    cyc(1'b1, 8'hEE, acc);
    // Reset coincides with a valid byte; that byte must be dropped.
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
    total++;
    if (got_a.size() !== 1 || (got_a.size() == 1 && (got_a[0] !== 5 || got_d[0] !== w0))) begin
      nbad++; $display("FAIL mid_first: got writes=%0d want 1 write a=5 d=%h", got_a.size(), w0);
    end
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    got_a.delete(); got_d.delete(); got_fin.delete();
    hdr_n = 1;
    words = '{32'h00000013};
    play(0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 8'($urandom), acc);
      total++;
      if (acc !== 1'b0) begin
        nbad++; $display("FAIL mid_trail%0d: got accepted=%b want 0", k, acc);
      end
    end
    idle(2);
    model(1024, 5);
    total++;
    if (got_a.size() !== 1 || (got_a.size() == 1 &&
        (got_a[0] !== exp_a[0] || got_d[0] !== exp_d[0] || got_fin[0] !== 1'b1))) begin
      nbad++;
      $display("FAIL mid_restart: got writes=%0d want 1 write a=%0d d=%h with done", got_a.size(), exp_a[0], exp_d[0]);
    end
    total++;
    if ({o_done, o_err, o_hold} !== 3'b100) begin
      nbad++; $display("FAIL mid_status: got done/err/hold=%b want 100", {o_done, o_err, o_hold});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_capacity();
    test_gaps();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
